// File: rtl/match_window_counter_if.sv
// -----------------------------------------------------------------------------
// match_window_counter_if
// Result-side bundle of the match window counter: the published window total
// and its valid/ack handshake toward a CPU or logger.
//   count_out   producer -> consumer  total of the last completed window
//   sat         producer -> consumer  that window's total was clamped
//   count_valid producer -> consumer  count_out holds an unconsumed result
//   overrun     producer -> consumer  sticky: a result was overwritten unread
//   count_ack   consumer -> producer  consumer takes the result
// -----------------------------------------------------------------------------
interface match_window_counter_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] count_out;
    logic             sat;
    logic             count_valid;
    logic             count_ack;
    logic             overrun;

    modport master (
        output count_out,
        output sat,
        output count_valid,
        output overrun,
        input  count_ack
    );

    modport slave (
        input  count_out,
        input  sat,
        input  count_valid,
        input  overrun,
        output count_ack
    );
endinterface

// File: rtl/match_window_counter.sv
// -----------------------------------------------------------------------------
// match_window_counter
// Counts the high cycles of a sequence detector's output over windows of
// WIN_LEN enabled cycles. Each window total, which saturates at 2**CNT_W-1, is
// published with a valid/ack handshake. Saturation is flagged alongside the
// total, and an overwrite of an unread result sets a sticky overrun flag.
// Ports:
//   clk      in  single clock, rising edge
//   rst      in  synchronous active-high reset
//   en       in  1 = window running, 0 = discard partial window and idle
//   Data_in  in  detector output, one count per high sample cycle
//   bus      master side of match_window_counter_if (result + handshake)
// -----------------------------------------------------------------------------
module match_window_counter #(
    parameter int CNT_W   = 8,
    parameter int WIN_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  Data_in,
    match_window_counter_if.master bus
);

    localparam int               WIN_W    = $clog2(WIN_LEN);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Saturating increment. Bit CNT_W is set when a clamp actually happened,
    // meaning a high input arrived while the value was already at maximum.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic             b);
        logic [CNT_W:0] res;
        if (b == 1'b1) begin
            if (a == CNT_MAX) begin
                res = {1'b1, CNT_MAX};
            end else begin
                res = {1'b0, a + CNT_W'(1)};
            end
        end else begin
            res = {1'b0, a};
        end
        return res;
    endfunction

    state_t           r_state,       w_state;
    logic [CNT_W-1:0] r_acc,         w_acc;
    logic             r_sat_acc,     w_sat_acc;
    logic [WIN_W-1:0] r_win_cnt,     w_win_cnt;
    logic [CNT_W-1:0] r_count_out,   w_count_out;
    logic             r_sat,         w_sat;
    logic             r_count_valid, w_count_valid;
    logic             r_overrun,     w_overrun;

    logic [CNT_W:0]   w_add;
    logic             w_win_end;
    logic             w_ack_taken;

    // Next-state and datapath decode for the window FSM and the result registers
    always_comb begin
        w_state       = r_state;
        w_acc         = r_acc;
        w_sat_acc     = r_sat_acc;
        w_win_cnt     = r_win_cnt;
        w_count_out   = r_count_out;
        w_sat         = r_sat;
        w_count_valid = r_count_valid;
        w_overrun     = r_overrun;

        w_add       = sat_add(r_acc, Data_in);
        w_win_end   = (r_win_cnt == WIN_LAST);
        w_ack_taken = r_count_valid & bus.count_ack;

        case (r_state)
            ST_IDLE: begin
                if (en == 1'b1) begin
                    w_state = ST_RUN;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (en == 1'b1) begin
                    w_state = ST_RUN;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        // An ack only matters while a result is pending. A window completing
        // in the same cycle overrides this below and keeps valid high.
        if (w_ack_taken == 1'b1) begin
            w_count_valid = 1'b0;
        end else begin
            w_count_valid = r_count_valid;
        end

        // Sampling depends only on en, because the first en-high cycle seen
        // from IDLE is already a sample cycle.
        if (en == 1'b1) begin
            if (w_win_end == 1'b1) begin
                w_count_out   = w_add[CNT_W-1:0];
                w_sat         = r_sat_acc | w_add[CNT_W];
                w_count_valid = 1'b1;
                if ((r_count_valid == 1'b1) && (bus.count_ack == 1'b0)) begin
                    w_overrun = 1'b1;
                end else begin
                    w_overrun = r_overrun;
                end
                w_acc     = {CNT_W{1'b0}};
                w_sat_acc = 1'b0;
                w_win_cnt = {WIN_W{1'b0}};
            end else begin
                w_acc     = w_add[CNT_W-1:0];
                w_sat_acc = r_sat_acc | w_add[CNT_W];
                w_win_cnt = r_win_cnt + WIN_W'(1);
            end
        end else begin
            // A dropped enable discards the partial window without reporting it.
            w_acc     = {CNT_W{1'b0}};
            w_sat_acc = 1'b0;
            w_win_cnt = {WIN_W{1'b0}};
        end
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst == 1'b1) begin
            r_state       <= ST_IDLE;
            r_acc         <= {CNT_W{1'b0}};
            r_sat_acc     <= 1'b0;
            r_win_cnt     <= {WIN_W{1'b0}};
            r_count_out   <= {CNT_W{1'b0}};
            r_sat         <= 1'b0;
            r_count_valid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_acc         <= w_acc;
            r_sat_acc     <= w_sat_acc;
            r_win_cnt     <= w_win_cnt;
            r_count_out   <= w_count_out;
            r_sat         <= w_sat;
            r_count_valid <= w_count_valid;
            r_overrun     <= w_overrun;
        end
    end

    assign bus.count_out   = r_count_out;
    assign bus.sat         = r_sat;
    assign bus.count_valid = r_count_valid;
    assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_match_window_counter.sv
// -----------------------------------------------------------------------------
// tb_match_window_counter
// Directed bench for match_window_counter. It uses two instances that share
// clk and rst: an 8-bit counter with WIN_LEN=16, and a 3-bit counter with
// WIN_LEN=16 for saturation. Inputs are driven 1 ns after each rising edge,
// and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_match_window_counter;

    logic clk = 1'b0;
    logic rst;
    logic en8, d8, en3, d3;

    int n_checks = 0;
    int n_fail   = 0;

    match_window_counter_if #(.CNT_W(8)) bus8 ();
    match_window_counter_if #(.CNT_W(3)) bus3 ();

    match_window_counter #(.CNT_W(8), .WIN_LEN(16)) u_dut8 (
        .clk     (clk),
        .rst     (rst),
        .en      (en8),
        .Data_in (d8),
        .bus     (bus8.master)
    );

    match_window_counter #(.CNT_W(3), .WIN_LEN(16)) u_dut3 (
        .clk     (clk),
        .rst     (rst),
        .en      (en3),
        .Data_in (d3),
        .bus     (bus3.master)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full 16-sample window on the 8-bit instance. Bit i of ones is the
    // value of Data_in at sample i. With ack_last set, ack is raised on the
    // window-end sample.
    task automatic win8(input logic [15:0] ones, input logic ack_last);
        for (int i = 0; i < 16; i++) begin
            d8 = ones[i];
            bus8.count_ack = ack_last & (i == 15);
            step();
        end
        d8 = 1'b0;
        bus8.count_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en8 = 1'b1; d8 = 1'b1; en3 = 1'b1; d3 = 1'b1;
        bus8.count_ack = 1'b0;
        bus3.count_ack = 1'b0;

        // 1: reset with en and Data_in high
        step();
        check_eq("rst1_valid8", 32'(bus8.count_valid), 32'd0);
        step();
        check_eq("rst_cnt8",     32'(bus8.count_out),   32'd0);
        check_eq("rst_sat8",     32'(bus8.sat),         32'd0);
        check_eq("rst_valid8",   32'(bus8.count_valid), 32'd0);
        check_eq("rst_ovr8",     32'(bus8.overrun),     32'd0);
        check_eq("rst_cnt3",     32'(bus3.count_out),   32'd0);
        check_eq("rst_valid3",   32'(bus3.count_valid), 32'd0);

        // 2: highs on samples 3, 4 and 10, then check latency and ack
        rst = 1'b0;
        en3 = 1'b0; d3 = 1'b0;
        en8 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d8 = ((i == 3) || (i == 4) || (i == 10)) ? 1'b1 : 1'b0;
            step();
            if (i == 14) check_eq("t2_not_early", 32'(bus8.count_valid), 32'd0);
        end
        check_eq("t2_cnt",   32'(bus8.count_out),   32'd3);
        check_eq("t2_sat",   32'(bus8.sat),         32'd0);
        check_eq("t2_valid", 32'(bus8.count_valid), 32'd1);
        en8 = 1'b0; d8 = 1'b0;
        step();
        check_eq("t2_hold_valid", 32'(bus8.count_valid), 32'd1);
        check_eq("t2_hold_cnt",   32'(bus8.count_out),   32'd3);
        bus8.count_ack = 1'b1;
        step();
        check_eq("t2_ack_clr", 32'(bus8.count_valid), 32'd0);
        step();
        check_eq("t2_ack_idle_valid", 32'(bus8.count_valid), 32'd0);
        check_eq("t2_ack_idle_ovr",   32'(bus8.overrun),     32'd0);
        bus8.count_ack = 1'b0;

        // 3: saturation on the 3-bit instance, then a 2-high window
        en3 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d3 = 1'b1;
            step();
        end
        check_eq("t3_cnt_sat",  32'(bus3.count_out),   32'd7);
        check_eq("t3_sat",      32'(bus3.sat),         32'd1);
        check_eq("t3_valid",    32'(bus3.count_valid), 32'd1);
        for (int i = 0; i < 16; i++) begin
            d3 = (i < 2) ? 1'b1 : 1'b0;
            bus3.count_ack = (i == 0) ? 1'b1 : 1'b0;
            step();
            if (i == 0) begin
                check_eq("t3_ack_clr",   32'(bus3.count_valid), 32'd0);
                check_eq("t3_stable",    32'(bus3.count_out),   32'd7);
                check_eq("t3_stable_sat",32'(bus3.sat),         32'd1);
            end
        end
        bus3.count_ack = 1'b0;
        check_eq("t3_cnt2",   32'(bus3.count_out),   32'd2);
        check_eq("t3_sat2",   32'(bus3.sat),         32'd0);
        check_eq("t3_valid2", 32'(bus3.count_valid), 32'd1);
        check_eq("t3_ovr2",   32'(bus3.overrun),     32'd0);
        en3 = 1'b0; d3 = 1'b0;

        // 4: two windows with no ack in between, so overrun becomes sticky
        en8 = 1'b1;
        win8(16'h001F, 1'b0);
        check_eq("t4_cnt5",  32'(bus8.count_out), 32'd5);
        check_eq("t4_ovr0",  32'(bus8.overrun),   32'd0);
        win8(16'h0080, 1'b0);
        check_eq("t4_cnt1",   32'(bus8.count_out),   32'd1);
        check_eq("t4_valid",  32'(bus8.count_valid), 32'd1);
        check_eq("t4_ovr1",   32'(bus8.overrun),     32'd1);
        en8 = 1'b0;
        bus8.count_ack = 1'b1;
        step();
        bus8.count_ack = 1'b0;
        check_eq("t4_ack_valid", 32'(bus8.count_valid), 32'd0);
        check_eq("t4_ovr_sticky",32'(bus8.overrun),     32'd1);
        step();
        check_eq("t4_ovr_sticky2", 32'(bus8.overrun), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t4_ovr_rst", 32'(bus8.overrun), 32'd0);

        // 5: ack in the same cycle that window 2 ends
        en8 = 1'b1;
        win8(16'h0006, 1'b0);
        check_eq("t5_cnt_w1", 32'(bus8.count_out), 32'd2);
        win8(16'h0070, 1'b1);
        check_eq("t5_cnt_w2", 32'(bus8.count_out),   32'd3);
        check_eq("t5_valid",  32'(bus8.count_valid), 32'd1);
        check_eq("t5_no_ovr", 32'(bus8.overrun),     32'd0);
        en8 = 1'b0;
        bus8.count_ack = 1'b1;
        step();
        bus8.count_ack = 1'b0;
        check_eq("t5_ack_clr", 32'(bus8.count_valid), 32'd0);

        // 6a: drop en after 9 samples holding 4 highs; the partial window is lost
        en8 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            d8 = ((i % 2) == 0 && i < 8) ? 1'b1 : 1'b0;
            step();
        end
        en8 = 1'b0; d8 = 1'b1;
        step();
        step();
        check_eq("t6_no_report", 32'(bus8.count_valid), 32'd0);
        check_eq("t6_cnt_kept",  32'(bus8.count_out),   32'd3);
        en8 = 1'b1;
        win8(16'h1020, 1'b0);
        check_eq("t6_cnt2",   32'(bus8.count_out),   32'd2);
        check_eq("t6_valid",  32'(bus8.count_valid), 32'd1);
        check_eq("t6_ovr",    32'(bus8.overrun),     32'd0);
        en8 = 1'b0;
        bus8.count_ack = 1'b1;
        step();
        bus8.count_ack = 1'b0;

        // 6b: reset in the middle of a window
        en8 = 1'b1; d8 = 1'b1;
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t6_rst_cnt",   32'(bus8.count_out),   32'd0);
        check_eq("t6_rst_valid", 32'(bus8.count_valid), 32'd0);
        win8(16'h0001, 1'b0);
        check_eq("t6_post_rst_cnt",   32'(bus8.count_out),   32'd1);
        check_eq("t6_post_rst_valid", 32'(bus8.count_valid), 32'd1);
        en8 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
